// File: rtl/des_wb_sequencer.sv
// Wishbone master that loads one block/key into the DES slave, runs start/poll/stop,
// reads the result back and hands it to a streaming consumer.
module des_wb_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned MAX_POLLS   = 255,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned FINISH_BIT  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int unsigned TMO_N  = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT : 1;
  localparam int unsigned POLL_N = (MAX_POLLS > 0) ? MAX_POLLS : 1;
  localparam int unsigned GAP_N  = (POLL_GAP > 0) ? POLL_GAP : 1;
  localparam int unsigned TW     = (TMO_N > 1) ? $clog2(TMO_N) : 1;
  localparam int unsigned PW     = $clog2(POLL_N + 1);
  localparam int unsigned GW     = (GAP_N > 1) ? $clog2(GAP_N) : 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_N - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_N - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_N - 1);

  localparam logic [31:0] REG_CFG = 32'h00;
  localparam logic [31:0] REG_TXH = 32'h04;
  localparam logic [31:0] REG_TXL = 32'h08;
  localparam logic [31:0] REG_RXH = 32'h0C;
  localparam logic [31:0] REG_RXL = 32'h10;
  localparam logic [31:0] REG_KH  = 32'h14;
  localparam logic [31:0] REG_KL  = 32'h18;

  typedef enum logic [3:0] {
    S_IDLE, S_W_RXH, S_W_RXL, S_W_KH, S_W_KL, S_W_START,
    S_R_STAT, S_GAP, S_W_STOP, S_R_TXH, S_R_TXL, S_OUT
  } state_e;

  state_e        state_q, state_d;
  state_e        issue_st;
  logic          issue;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic          out_err_q, out_err_d;
  logic [63:0]   out_data_q, out_data_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   key_q, key_d;
  logic          mode_q, mode_d;
  logic [31:0]   txh_q, txh_d;
  logic          exhaust_q, exhaust_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_data_d  = out_data_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    data_d      = data_q;
    key_d       = key_q;
    mode_d      = mode_q;
    txh_d       = txh_q;
    exhaust_d   = exhaust_q;
    tmo_d       = tmo_q;
    poll_d      = poll_q;
    gap_d       = gap_q;
    issue       = 1'b0;
    issue_st    = state_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d     = in_data;
          key_d      = in_key;
          mode_d     = in_mode;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          out_err_d  = 1'b0;
          exhaust_d  = 1'b0;
          poll_d     = '0;
          issue      = 1'b1;
          issue_st   = S_W_RXH;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          issue    = 1'b1;
          issue_st = S_R_STAT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          out_data_d  = '0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        // Bus states: cyc low means this is the one-cycle gap before the request.
        if (!cyc_q) begin
          issue    = 1'b1;
          issue_st = state_q;
        end else if (wbm_ack_i) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          sel_d = '0;
          adr_d = '0;
          dat_d = '0;
          case (state_q)
            S_W_RXH:   state_d = S_W_RXL;
            S_W_RXL:   state_d = S_W_KH;
            S_W_KH:    state_d = S_W_KL;
            S_W_KL:    state_d = S_W_START;
            S_W_START: state_d = S_R_STAT;
            S_R_STAT: begin
              poll_d = poll_q + 1'b1;
              if (wbm_dat_i[FINISH_BIT]) begin
                state_d = S_W_STOP;
              end else if (poll_q == POLL_LAST) begin
                state_d   = S_W_STOP;
                exhaust_d = 1'b1;
              end else begin
                state_d = S_GAP;
                gap_d   = '0;
              end
            end
            S_W_STOP: begin
              if (exhaust_q) begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                out_err_d   = 1'b1;
                out_data_d  = '0;
              end else begin
                state_d = S_R_TXH;
              end
            end
            S_R_TXH: begin
              txh_d   = wbm_dat_i;
              state_d = S_R_TXL;
            end
            S_R_TXL: begin
              out_data_d  = {txh_q, wbm_dat_i};
              out_valid_d = 1'b1;
              out_err_d   = 1'b0;
              state_d     = S_OUT;
            end
            default: state_d = S_IDLE;
          endcase
        end else if (tmo_q == TMO_LAST) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          adr_d       = '0;
          dat_d       = '0;
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_data_d  = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    endcase

    // Every access launches here, so the accept edge can start the first write directly.
    if (issue) begin
      state_d = issue_st;
      cyc_d   = 1'b1;
      tmo_d   = '0;
      we_d    = 1'b1;
      sel_d   = 4'hF;
      dat_d   = '0;
      adr_d   = REG_CFG;
      case (issue_st)
        S_W_RXH:   begin adr_d = REG_RXH; dat_d = data_d[63:32]; end
        S_W_RXL:   begin adr_d = REG_RXL; dat_d = data_d[31:0];  end
        S_W_KH:    begin adr_d = REG_KH;  dat_d = key_d[63:32];  end
        S_W_KL:    begin adr_d = REG_KL;  dat_d = key_d[31:0];   end
        S_W_START: begin
          sel_d = 4'b0110;
          dat_d = 32'h0000_0100 | (32'(mode_d) << 16);
        end
        S_R_STAT:  we_d = 1'b0;
        S_W_STOP:  sel_d = 4'b0010;
        S_R_TXH:   begin adr_d = REG_TXH; we_d = 1'b0; end
        S_R_TXL:   begin adr_d = REG_TXL; we_d = 1'b0; end
        default:   cyc_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      data_q      <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      txh_q       <= '0;
      exhaust_q   <= 1'b0;
      tmo_q       <= '0;
      poll_q      <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      data_q      <= data_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      txh_q       <= txh_d;
      exhaust_q   <= exhaust_d;
      tmo_q       <= tmo_d;
      poll_q      <= poll_d;
      gap_q       <= gap_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_data  = out_data_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_des_wb_sequencer.sv
// Bench for des_wb_sequencer: behavioural DES slave with known vectors, bus-trace
// and result scoreboards fed by directed stimulus.
module tb_des_wb_sequencer;

  localparam int unsigned TB_TMO  = 16;
  localparam int unsigned TB_GAP  = 4;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_mode;
  logic [63:0] in_data, in_key;
  logic        out_valid, out_ready, out_err, busy;
  logic [63:0] out_data;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  des_wb_sequencer #(
    .ACK_TIMEOUT(TB_TMO),
    .MAX_POLLS  (3),
    .POLL_GAP   (TB_GAP),
    .FINISH_BIT (0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .busy(busy),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Known DES vectors; anything else yields a poison value.
  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] k, input logic m);
    if (k == KEY && !m && blk == PT) return CT;
    if (k == KEY &&  m && blk == CT) return PT;
    return 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  // Slave model
  bit          finish_never = 1'b0;
  bit          nack_en = 1'b0;
  logic [31:0] nack_adr = 32'h0;
  logic [31:0] s_rxh, s_rxl, s_kh, s_kl, s_txh, s_txl;
  logic        s_run, s_mode, s_fin;
  int unsigned s_cnt;

  assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & !(nack_en && wbm_adr_o == nack_adr);

  always_comb begin
    wbm_dat_i = '0;
    case (wbm_adr_o)
      32'h00: wbm_dat_i = {15'b0, s_mode, 7'b0, s_run, 7'b0, s_fin};
      32'h04: wbm_dat_i = s_txh;
      32'h08: wbm_dat_i = s_txl;
      32'h0C: wbm_dat_i = s_rxh;
      32'h10: wbm_dat_i = s_rxl;
      32'h14: wbm_dat_i = s_kh;
      32'h18: wbm_dat_i = s_kl;
      default: wbm_dat_i = '0;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s_rxh, s_rxl, s_kh, s_kl, s_txh, s_txl} <= '0;
      s_run <= 1'b0; s_mode <= 1'b0; s_fin <= 1'b0; s_cnt <= 0;
    end else if (wbm_ack_i && wbm_we_o) begin
      case (wbm_adr_o)
        32'h0C: s_rxh <= wbm_dat_o;
        32'h10: s_rxl <= wbm_dat_o;
        32'h14: s_kh  <= wbm_dat_o;
        32'h18: s_kl  <= wbm_dat_o;
        32'h00: begin
          if (wbm_sel_o[2]) s_mode <= wbm_dat_o[16];
          if (wbm_sel_o[1]) begin
            s_run <= wbm_dat_o[8];
            s_fin <= 1'b0;
            s_cnt <= 3;
          end
        end
        default: ;
      endcase
    end else if (s_run && !s_fin && !finish_never) begin
      if (s_cnt != 0) s_cnt <= s_cnt - 1;
      else begin
        s_fin <= 1'b1;
        {s_txh, s_txl} <= des_ref({s_rxh, s_rxl}, {s_kh, s_kl}, s_mode);
      end
    end
  end

  // Scoreboards
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          gap;
    bit          abort;
  } acc_t;
  typedef struct {
    logic [63:0] data;
    logic        err;
  } res_t;

  acc_t exp_bus[$];
  res_t exp_out[$];

  task automatic push_acc(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, input int g, input bit ab);
    acc_t e;
    e.adr = a; e.we = w; e.sel = s; e.dat = d; e.gap = g; e.abort = ab;
    exp_bus.push_back(e);
  endtask

  task automatic push_run(input logic [63:0] d, input logic [63:0] k, input logic m,
                          input int unsigned npolls, input bit exhaust);
    push_acc(32'h0C, 1'b1, 4'hF, d[63:32], -1, 1'b0);
    push_acc(32'h10, 1'b1, 4'hF, d[31:0], 1, 1'b0);
    push_acc(32'h14, 1'b1, 4'hF, k[63:32], 1, 1'b0);
    push_acc(32'h18, 1'b1, 4'hF, k[31:0], 1, 1'b0);
    push_acc(32'h00, 1'b1, 4'b0110, m ? 32'h0001_0100 : 32'h0000_0100, 1, 1'b0);
    for (int unsigned i = 0; i < npolls; i++)
      push_acc(32'h00, 1'b0, 4'hF, 32'h0, (i == 0) ? 1 : int'(TB_GAP), 1'b0);
    push_acc(32'h00, 1'b1, 4'b0010, 32'h0, 1, 1'b0);
    if (!exhaust) begin
      push_acc(32'h04, 1'b0, 4'hF, 32'h0, 1, 1'b0);
      push_acc(32'h08, 1'b0, 4'hF, 32'h0, 1, 1'b0);
    end
  endtask

  task automatic push_res(input logic [63:0] d, input logic e);
    res_t r;
    r.data = d; r.err = e;
    exp_out.push_back(r);
  endtask

  int unsigned req_cycles = 0, idle_cnt = 0, gap_seen = 0;
  logic [31:0] c_adr, c_dat;
  logic        c_we;
  logic [3:0]  c_sel;
  bit          hold_bad;

  task automatic check_access(input bit aborted);
    acc_t e;
    if (exp_bus.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL bus_unexpected: access adr %h we %b, none expected", c_adr, c_we);
    end else begin
      e = exp_bus.pop_front();
      chk("bus_adr", c_adr, e.adr);
      chk("bus_we", c_we, e.we);
      chk("bus_sel", c_sel, e.sel);
      chk("bus_dat", c_dat, e.dat);
      chk("bus_hold", hold_bad, 0);
      chk("bus_abort", aborted, e.abort);
      if (e.gap >= 0) chk("bus_gap", gap_seen, e.gap);
      if (e.abort) chk("bus_tmo_cycles", req_cycles, TB_TMO);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      req_cycles = 0;
      idle_cnt = 0;
    end else if (wbm_cyc_o) begin
      if (req_cycles == 0) begin
        gap_seen = idle_cnt;
        c_adr = wbm_adr_o; c_dat = wbm_dat_o; c_we = wbm_we_o; c_sel = wbm_sel_o;
        hold_bad = 1'b0;
      end else if ({wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o} !== {c_adr, c_dat, c_we, c_sel}) begin
        hold_bad = 1'b1;
      end
      if (wbm_stb_o !== 1'b1) hold_bad = 1'b1;
      req_cycles++;
      if (wbm_ack_i) begin
        check_access(1'b0);
        req_cycles = 0;
        idle_cnt = 0;
      end
    end else begin
      if (req_cycles != 0) begin
        check_access(1'b1);
        req_cycles = 0;
        idle_cnt = 0;
      end
      idle_cnt++;
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (rst_n && out_valid && out_ready) begin
      if (exp_out.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out_unexpected: data %h err %b, none expected", out_data, out_err);
      end else begin
        r = exp_out.pop_front();
        chk("out_data", out_data, r.data);
        chk("out_err", out_err, r.err);
      end
    end
  end

  // Stimulus
  task automatic send(input logic [63:0] d, input logic [63:0] k, input logic m);
    bit got = 1'b0;
    @(posedge clk); #1;
    in_data = d; in_key = k; in_mode = m; in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("accept_in_ready", in_ready, 0);
    chk("accept_busy", busy, 1);
  endtask

  task automatic wait_out();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_out.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL out_timeout: %0d results pending, expected 0", exp_out.size());
    end
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_cyc", wbm_cyc_o, 0);
    chk("bus_left", exp_bus.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; in_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_we", wbm_we_o, 0);
    chk("rst_sel", wbm_sel_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_data", out_data, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Encrypt and decrypt, slave finishes on the second status read
    push_run(PT, KEY, 1'b0, 2, 1'b0); push_res(CT, 1'b0);
    send(PT, KEY, 1'b0); wait_out();
    push_run(CT, KEY, 1'b1, 2, 1'b0); push_res(PT, 1'b0);
    send(CT, KEY, 1'b1); wait_out();

    // Backpressure on the result
    out_ready = 1'b0;
    push_run(PT, KEY, 1'b0, 2, 1'b0); push_res(CT, 1'b0);
    send(PT, KEY, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    chk("bp_valid_seen", found, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; in_data = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, CT);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_out();

    // Ack timeout on KEY_H32
    nack_en = 1'b1; nack_adr = 32'h14;
    push_acc(32'h0C, 1'b1, 4'hF, PT[63:32], -1, 1'b0);
    push_acc(32'h10, 1'b1, 4'hF, PT[31:0], 1, 1'b0);
    push_acc(32'h14, 1'b1, 4'hF, KEY[63:32], 1, 1'b1);
    push_res(64'h0, 1'b1);
    send(PT, KEY, 1'b0); wait_out();
    nack_en = 1'b0;

    // Poll exhaustion
    finish_never = 1'b1;
    push_run(PT, KEY, 1'b0, 3, 1'b1); push_res(64'h0, 1'b1);
    send(PT, KEY, 1'b0); wait_out();

    // Reset while a status read is on the bus
    push_run(PT, KEY, 1'b0, 3, 1'b1);
    send(PT, KEY, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_adr_o == 32'h0 && !wbm_we_o) found = 1'b1;
    end
    chk("stat_seen", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", wbm_cyc_o, 0);
    chk("arst_stb", wbm_stb_o, 0);
    chk("arst_busy", busy, 0);
    exp_bus.delete();
    exp_out.delete();
    finish_never = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    push_run(PT, KEY, 1'b0, 2, 1'b0); push_res(CT, 1'b0);
    send(PT, KEY, 1'b0); wait_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/des_wb_sequencer.md
# des_wb_sequencer

- Wishbone master that drives the DES Wishbone slave (register offsets below) on behalf of a streaming client.
- Accepts one 64-bit block, a 64-bit key and a mode over a valid/ready handshake.
- Runs the complete bus transaction sequence: load, start, poll, stop, read back.
- Returns the 64-bit result over a second valid/ready handshake. Sits directly upstream of the DES slave and replaces a CPU.

## Interface
- `ACK_TIMEOUT`, default 64: max cycles a request may wait for `wbm_ack_i` before abort.
- `MAX_POLLS`, default 255: max status reads before declaring failure.
- `POLL_GAP`, default 4: idle cycles between consecutive status reads.
- `FINISH_BIT`, default 0: bit of the REG_CFG readback that signals completion.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: high only in IDLE.
- `in_data` in 64: plaintext or ciphertext; [63:32] = H32.
- `in_key` in 64: key; [63:32] = H32.
- `in_mode` in 1: 0 = encrypt, 1 = decrypt.
- `out_valid` out 1: result present; held until `out_ready`.
- `out_ready` in 1: consumer accepts.
- `out_data` out 64: result {TRANSMIT_H32, TRANSMIT_L32}; 0 when `out_err`.
- `out_err` out 1: qualifies `out_valid`; 1 = ack timeout or poll exhaustion.
- `busy` out 1: high in every state except IDLE.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: Wishbone master controls.
- `wbm_sel_o` out 4: byte select.
- `wbm_adr_o` out 32: slave offset.
- `wbm_dat_o` out 32: write data.
- `wbm_ack_i` in 1: slave acknowledge.
- `wbm_dat_i` in 32: read data.

## Operation
- Register map:
  - 0x00 REG_CFG
  - 0x04 TRANSMIT_H32
  - 0x08 TRANSMIT_L32
  - 0x0C RECEIVE_H32
  - 0x10 RECEIVE_L32
  - 0x14 KEY_H32
  - 0x18 KEY_L32
- Handshake `in_valid & in_ready` captures data, key and mode into internal registers.
- State sequence: IDLE → W_RXH → W_RXL → W_KH → W_KL → W_START → R_STAT → (GAP → R_STAT)* → W_STOP → R_TXH → R_TXL → OUT → IDLE.
- Data writes (RXH, RXL, KH, KL): `sel` = 4'hF, `we` = 1, data = corresponding captured half.
- W_START: `sel` = 4'b0110, data = 0x0000_0100 | (mode << 16), i.e. 0x100 for encrypt, 0x10100 for decrypt.
- W_STOP: `sel` = 4'b0010, data = 0.
- Reads (STAT, TXH, TXL): `sel` = 4'hF, `we` = 0; `wbm_dat_o` = 0.
- R_STAT: if `wbm_dat_i[FINISH_BIT]` = 1 at ack, go to W_STOP. Otherwise go to GAP (`POLL_GAP` idle cycles), then R_STAT again.
- Poll counter counts R_STAT acks. Reaching `MAX_POLLS` without finish: go to W_STOP, then directly to OUT with `out_err` = 1 (TX reads skipped).
- Ack timeout, any access:
  - Drop `cyc`/`stb` next cycle and go to OUT with `out_err` = 1 and `out_data` = 0.
  - No stop write is issued.
  - The timeout counter reloads at every new access.
- OUT: `out_valid` = 1 until `out_ready`; the transfer returns the block to IDLE.

## Timing
- Reset (async assert): `busy`, `out_valid`, `out_err`, `out_data` and all `wbm_*` outputs = 0; state = IDLE; `in_ready` = 1 after reset release.
- Reset mid-operation: bus released immediately (`cyc`/`stb` low asynchronously); pending result discarded.
- All `wbm_*`, `out_*` and `busy` outputs are registered.
- Bus access sequence:
  - First access asserted the cycle after the input handshake.
  - `cyc`, `stb`, `we`, `adr`, `sel` and `dat` assert together and are held constant until a rising edge samples `wbm_ack_i` = 1.
  - Read data is captured on that same edge.
  - `cyc`/`stb` are low for exactly 1 cycle before the next access. No pipelined or burst cycles.
- Slave acking on the first cycle of `stb`: each access costs 2 cycles (1 request + 1 gap). Timeout fires when ack is not seen within `ACK_TIMEOUT` request cycles.
- `out_valid` rises the cycle after the R_TXL ack edge (or the cycle after the abort decision).
- `in_ready` is low from the accept cycle until the cycle after the OUT handshake. `in_valid` during busy is ignored.
- `busy` rises the cycle after accept and falls with the OUT handshake.

## Test plan
- Encrypt: data 0x0123456789ABCDEF, key 0x133457799BBCDFF1, mode 0, against the DES slave.
  - `out_data` = 0x85E813540F0AB405, `out_err` = 0.
  - Bus address trace: C, 10, 14, 18, 0(w), 0(r)…, 0(w), 4, 8.
- Decrypt: data 0x85E813540F0AB405, same key, mode 1 → `out_data` = 0x0123456789ABCDEF; W_START data = 0x10100 with `sel` 0110.
- Backpressure: hold `out_ready` = 0 for 20 cycles → `out_valid` and `out_data` stable; `in_valid` pulses are not accepted; one handshake returns the block to IDLE.
- Ack timeout: slave model never acks the W_KH access → after `ACK_TIMEOUT` cycles, `cyc` drops, `out_valid` = 1, `out_err` = 1, `out_data` = 0.
- Poll exhaustion with `MAX_POLLS` = 3 and finish never set → 3 status reads spaced `POLL_GAP` apart, one stop write, then `out_err` = 1 with no TX reads.
- Reset asserted during R_STAT → `cyc`/`stb` low immediately. After release: `in_ready` = 1, `out_valid` = 0, and a fresh encrypt produces the correct result.
